// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state type and default operand width.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mult_ctrl.sv
// Sequencer for the shift-and-add multiplier: IDLE/RUN/DONE FSM plus iteration counter.
// With MUL_EARLY_EXIT_EN defined, RUN also ends once the remaining multiplier bits are all zero.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
`ifdef MUL_EARLY_EXIT_EN
  input  logic mplr_last,
`endif
  output logic load,
  output logic step,
  output logic finish,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(WIDTH + 1);

  mult_state_t   state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          last_iter;

`ifdef MUL_EARLY_EXIT_EN
  assign last_iter = (cnt_reg == CW'(WIDTH - 1)) || mplr_last;
`else
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        step     = 1'b1;
        cnt_next = cnt_reg + CW'(1);
        // finish marks the edge that enters DONE, so the product register loads exactly then
        if (last_iter) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned sequential shift-and-add multiplier, one multiplier bit per clock.
// Optional MUL_EARLY_EXIT_EN stops once the remaining multiplier bits are zero.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clock,
  input  logic               mul_reset_n,
  input  logic               mul_start,
  input  logic [WIDTH-1:0]   mul_a_in,
  input  logic [WIDTH-1:0]   mul_b_in,
  output logic               mul_busy,
  output logic               mul_done,
  output logic [2*WIDTH-1:0] mul_product_out
);

  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplr_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] product_reg;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_next;
  logic               load, step, finish;

  mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clock     (clock),
    .reset_n   (mul_reset_n),
    .start     (mul_start),
`ifdef MUL_EARLY_EXIT_EN
    .mplr_last (mplr_reg[WIDTH-1:1] == '0),
`endif
    .load      (load),
    .step      (step),
    .finish    (finish),
    .busy      (mul_busy),
    .done      (mul_done)
  );

  // Partial product: shifted multiplicand gated by the current multiplier LSB
  for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
    assign addend[gi] = mcand_reg[gi] & mplr_reg[0];
  end

  assign acc_next = acc_reg + addend;

  always_ff @(posedge clock or negedge mul_reset_n) begin
    if (!mul_reset_n) begin
      mcand_reg   <= '0;
      mplr_reg    <= '0;
      acc_reg     <= '0;
      product_reg <= '0;
    end else if (load) begin
      mcand_reg <= {{WIDTH{1'b0}}, mul_a_in};
      mplr_reg  <= mul_b_in;
      acc_reg   <= '0;
    end else if (step) begin
      acc_reg   <= acc_next;
      mcand_reg <= mcand_reg << 1;
      mplr_reg  <= mplr_reg >> 1;
      if (finish) begin
        product_reg <= acc_next;
      end
    end
  end

  assign mul_product_out = product_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier (WIDTH=16); honours MUL_EARLY_EXIT_EN for latency.
module tb_shift_add_multiplier;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
    int             start_edge;
    int             lat;
  } exp_t;

  logic           clock = 1'b0;
  logic           mul_reset_n = 1'b0;
  logic           mul_start = 1'b0;
  logic [W-1:0]   mul_a_in = '0;
  logic [W-1:0]   mul_b_in = '0;
  logic           mul_busy;
  logic           mul_done;
  logic [2*W-1:0] mul_product_out;

  int   total = 0;
  int   bad = 0;
  int   cycle_cnt = 0;
  int   busy_cnt = 0;
  logic prev_done = 1'b0;
  logic [2*W-1:0] last_prod = '0;
  exp_t sb[$];

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clock           (clock),
    .mul_reset_n     (mul_reset_n),
    .mul_start       (mul_start),
    .mul_a_in        (mul_a_in),
    .mul_b_in        (mul_b_in),
    .mul_busy        (mul_busy),
    .mul_done        (mul_done),
    .mul_product_out (mul_product_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Edges from accepting start to the edge that enters DONE
  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int m = 0;
    for (int i = 0; i < W; i++) if (b[i]) m = i;
    return m + 1;
`else
    return W;
`endif
  endfunction

  function automatic exp_t make_exp(input logic [W-1:0] a, input logic [W-1:0] b, input int se);
    exp_t e;
    logic [2*W-1:0] aw, bw;
    aw = {{W{1'b0}}, a};
    bw = {{W{1'b0}}, b};
    e.a = a; e.b = b; e.prod = aw * bw; e.start_edge = se; e.lat = exp_lat(b);
    return e;
  endfunction

  // Monitor: pops the scoreboard on every mul_done
  always @(negedge clock) begin
    if (!mul_reset_n) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (mul_busy) busy_cnt++;
      if (mul_done && prev_done) check("done_pulse", 1, 0);
      if (mul_done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("txn a=%h b=%h prod=%h lat=%0d", e.a, e.b, mul_product_out, cycle_cnt - e.start_edge);
          check("product", mul_product_out, e.prod);
          check("latency", cycle_cnt - e.start_edge, e.lat);
          check("busy_len", busy_cnt, e.lat);
          check("busy_at_done", mul_busy, 0);
          last_prod = e.prod;
        end
        busy_cnt = 0;
      end
      prev_done = mul_done;
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    mul_start = 1'b1;
    mul_a_in  = a;
    mul_b_in  = b;
    @(posedge clock);
    #1;
    mul_start = 1'b0;
    sb.push_back(make_exp(a, b, cycle_cnt));
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      check("timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (3) @(negedge clock);
    check("product_hold", mul_product_out, last_prod);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    check("rst_busy", mul_busy, 0);
    check("rst_done", mul_done, 0);
    check("rst_prod", mul_product_out, 0);
    mul_reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Basic, extremes and zero operands
    start_op(16'd3, 16'd5);        wait_idle(40);
    start_op(16'hFFFF, 16'hFFFF);  wait_idle(40);
    start_op(16'h1234, 16'h0000);  wait_idle(40);
    start_op(16'h0000, 16'hBEEF);  wait_idle(40);
    start_op(16'd7, 16'd1);        wait_idle(40);
    start_op(16'h0003, 16'h8000);  wait_idle(40);

    // Start while busy with different operands is ignored
    start_op(16'h00A5, 16'h0F0F);
    repeat (3) @(negedge clock);
    mul_start = 1'b1; mul_a_in = 16'hAAAA; mul_b_in = 16'h5555;
    @(negedge clock);
    mul_start = 1'b0;
    wait_idle(40);

    // Start held high through DONE: back-to-back
    begin
      bit seen = 0;
      @(negedge clock);
      mul_start = 1'b1; mul_a_in = 16'h0101; mul_b_in = 16'h8003;
      @(posedge clock); #1;
      sb.push_back(make_exp(16'h0101, 16'h8003, cycle_cnt));
      @(negedge clock);
      mul_a_in = 16'h4321; mul_b_in = 16'h00F7;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clock);
        if (mul_done) seen = 1;
      end
      check("b2b_first_done", seen, 1);
      sb.push_back(make_exp(16'h4321, 16'h00F7, cycle_cnt + 1));
      @(posedge clock); #1;
      mul_start = 1'b0;
      @(negedge clock);
      check("b2b_busy", mul_busy, 1);
      wait_idle(40);
    end

    // Reset in the middle of an operation
    start_op(16'h00FF, 16'hFFFF);
    repeat (8) @(negedge clock);
    mul_reset_n = 1'b0;
    sb.delete();
    #1;
    check("abort_busy", mul_busy, 0);
    check("abort_done", mul_done, 0);
    check("abort_prod", mul_product_out, 0);
    repeat (2) @(negedge clock);
    mul_reset_n = 1'b1;
    last_prod = '0;
    repeat (20) @(negedge clock);
    check("abort_no_done_prod", mul_product_out, 0);
    start_op(16'h1357, 16'h2468);  wait_idle(40);

    // Random operands
    for (int n = 0; n < 8; n++) begin
      start_op(16'($urandom), 16'($urandom));
      wait_idle(40);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter: WIDTH, default 16, operand width in bits (min 2).
REQ-002 SHALL have ports (clock and reset first):
- clock  input  1  rising-edge clock.
- mul_reset_n  input  1  asynchronous active-low reset.
- mul_start  input  1  request to begin a multiplication.
- mul_a_in  input  WIDTH  multiplicand, unsigned.
- mul_b_in  input  WIDTH  multiplier, unsigned.
- mul_busy  output  1  high while an operation is in progress.
- mul_done  output  1  one-cycle pulse when the product is valid.
- mul_product_out  output  2*WIDTH  product, unsigned.
REQ-003 SHALL use one clock domain; reset SHALL be asynchronous and active-low.

Function
REQ-004 SHALL implement an FSM with the states IDLE, RUN and DONE.
REQ-005 IDLE or DONE, with mul_start=1 at an edge: SHALL latch mul_a_in (zero-extended to 2*WIDTH) and mul_b_in, clear the accumulator and iteration counter, and go to RUN.
REQ-006 RUN, each cycle: if the multiplier LSB is 1, accumulator += shifted multiplicand (2*WIDTH-bit, no overflow possible); then multiplicand <<= 1, multiplier >>= 1, counter += 1.
REQ-007 RUN SHALL go to DONE after the WIDTH-th iteration; counter width SHALL be $clog2(WIDTH+1).
REQ-008 Latency: start sampled at edge k -> mul_done=1 during cycle k+WIDTH+1 (no early exit).
REQ-009 DONE SHALL last exactly one cycle. mul_done=1 only in DONE. The next state is IDLE, or RUN if mul_start=1.
REQ-010 mul_busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-011 mul_product_out SHALL be updated only on entry to DONE and held until the next DONE or reset.
REQ-012 mul_start in RUN SHALL be ignored; operand inputs SHALL be don't-care except at an accepted start.
REQ-013 Operand 0 (either) SHALL give product 0 with normal latency; all-ones x all-ones SHALL give (2^WIDTH-1)^2 exactly.

Reset
REQ-014 While mul_reset_n=0: state=IDLE; mul_busy=0; mul_done=0; mul_product_out=0; accumulator, operand registers and counter=0.
REQ-015 Reset asserted mid-RUN SHALL abort the operation with no mul_done pulse. Release SHALL take effect on the next rising clock edge.

Configuration
REQ-016 Macro MUL_EARLY_EXIT_EN:
- When defined, RUN SHALL go to DONE after any iteration that leaves the shifted multiplier zero. Latency is then (index of highest set bit of mul_b_in)+2 cycles from start to mul_done, and mul_b_in=0 SHALL finish after 1 RUN cycle.
- When undefined, latency SHALL always be as in REQ-008.
- The product value SHALL be identical in both builds.

Structure
REQ-017 A shared package mult_pkg SHALL hold the FSM state enum type (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-018 The FSM and counter SHALL be one sub-module, mult_ctrl, with outputs load, step, finish and busy. The datapath (operand, accumulator and product registers) SHALL stay in shift_add_multiplier.

Verification (WIDTH=16)
REQ-019 Start with a=3, b=5 -> mul_done pulse 17 cycles after start, product 0x0000000F, mul_busy high for 16 cycles.
REQ-020 a=0xFFFF, b=0xFFFF -> product 0xFFFE0001; a=0x1234, b=0 -> product 0, normal latency.
REQ-021 Start pulse while busy with different operands -> ignored, first result delivered unchanged; start held high through DONE -> back-to-back operation, mul_busy high the cycle after mul_done.
REQ-022 mul_reset_n low at iteration 8 of 16 -> outputs 0 immediately, no mul_done, then a new start gives a correct result.
REQ-023 With MUL_EARLY_EXIT_EN: a=7, b=1 -> mul_done 2 cycles after start, product 7; b=0x8000 -> 17 cycles; random operands -> products match the build without the macro.
